// File: rtl/fc_core_pkg.sv
// Shared FC-core definitions: FSM encoding, default widths and the element-to-bit-slice mapping
// used by both the BRAM reader and the stream writer.
package fc_core_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_CNT_BIT       = 31;
  localparam int DEF_DWIDTH        = 32;
  localparam int DEF_AWIDTH        = 12;
  localparam int DEF_MEM_SIZE      = 4096;
  localparam int DEF_IN_DATA_WIDTH = 8;
  localparam int DEF_NUM_CORE      = 4;

  // Element k lives at [lsb +: iwidth]; element 0 occupies the MSBs.
  function automatic int elem_lsb(input int k, input int dwidth, input int iwidth);
    return dwidth - (k + 1) * iwidth;
  endfunction

endpackage

// File: rtl/elem_packer.sv
// Packs NUM_CORE stream elements into one word, first element in the MSBs.
// word_valid/word are combinational so the completed word can be registered into the BRAM drive.
module elem_packer
  import fc_core_pkg::*;
#(
  parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
  parameter int NUM_CORE      = DEF_NUM_CORE,
  parameter int DWIDTH        = DEF_DWIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     elem_valid,
  input  logic [IN_DATA_WIDTH-1:0] elem_data,
  output logic                     word_valid,
  output logic [DWIDTH-1:0]        word
);

  localparam int IDXW = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NUM_CORE - 1);

  logic [IDXW-1:0]   idx;
  logic [DWIDTH-1:0] pack_r;
  logic [DWIDTH-1:0] merged;

  // The incoming element overlays its slot so the final element completes the word in the same cycle.
  for (genvar k = 0; k < NUM_CORE; k++) begin : g_slot
    localparam int LSB = elem_lsb(k, DWIDTH, IN_DATA_WIDTH);
    localparam logic [IDXW-1:0] KI = IDXW'(k);
    assign merged[LSB +: IN_DATA_WIDTH] =
      (idx == KI) ? elem_data : pack_r[LSB +: IN_DATA_WIDTH];
  end

  assign word_valid = elem_valid && (idx == LAST);
  assign word       = merged;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx    <= '0;
      pack_r <= '0;
    end else if (clr) begin
      idx    <= '0;
      pack_r <= '0;
    end else if (elem_valid) begin
      pack_r <= merged;
      idx    <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/bram_stream_writer.sv
// Fills a true_dpbram port from a valid/ready element stream, NUM_CORE elements per word from address 0.
// Optional BRAM_STREAM_WRITER_CHECKSUM_EN adds o_checksum, the running sum of words written since start.
module bram_stream_writer
  import fc_core_pkg::*;
#(
  parameter int CNT_BIT       = DEF_CNT_BIT,
  parameter int DWIDTH        = DEF_DWIDTH,
  parameter int AWIDTH        = DEF_AWIDTH,
  parameter int MEM_SIZE      = DEF_MEM_SIZE,
  parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
  parameter int NUM_CORE      = DEF_NUM_CORE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_run,
  input  logic [CNT_BIT-1:0]       i_num_cnt,
  output logic                     o_idle,
  output logic                     o_write,
  output logic                     o_done,
  input  logic                     s_valid,
  input  logic [IN_DATA_WIDTH-1:0] s_data,
  output logic                     s_ready,
  output logic [AWIDTH-1:0]        addr_b,
  output logic                     ce_b,
  output logic                     we_b,
  output logic [DWIDTH-1:0]        d_b
`ifdef BRAM_STREAM_WRITER_CHECKSUM_EN
  ,
  output logic [DWIDTH-1:0]        o_checksum
`endif
);

  localparam logic [AWIDTH-1:0] ADDR_LAST = AWIDTH'(MEM_SIZE - 1);

  state_t             state;
  logic [CNT_BIT-1:0] num_r;
  logic [CNT_BIT-1:0] acc_words;
  logic [AWIDTH-1:0]  addr_r;
  logic               start;
  logic               elem_acc;
  logic               word_valid;
  logic [DWIDTH-1:0]  word;

  assign start    = (state == S_IDLE) && i_run;
  assign s_ready  = (state == S_RUN) && (acc_words < num_r);
  assign elem_acc = s_valid && s_ready;

  elem_packer #(
    .IN_DATA_WIDTH(IN_DATA_WIDTH),
    .NUM_CORE     (NUM_CORE),
    .DWIDTH       (DWIDTH)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (start),
    .elem_valid(elem_acc),
    .elem_data (s_data),
    .word_valid(word_valid),
    .word      (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      o_idle    <= 1'b1;
      o_write   <= 1'b0;
      o_done    <= 1'b0;
      num_r     <= '0;
      acc_words <= '0;
      addr_r    <= '0;
      addr_b    <= '0;
      ce_b      <= 1'b0;
      we_b      <= 1'b0;
      d_b       <= '0;
    end else begin
      ce_b   <= 1'b0;
      we_b   <= 1'b0;
      o_done <= 1'b0;
      // Word completion only happens in RUN, so it never collides with the start-time clears.
      if (word_valid) begin
        ce_b      <= 1'b1;
        we_b      <= 1'b1;
        d_b       <= word;
        addr_b    <= addr_r;
        addr_r    <= (addr_r == ADDR_LAST) ? '0 : addr_r + 1'b1;
        acc_words <= acc_words + 1'b1;
      end
      case (state)
        S_IDLE: if (i_run) begin
          num_r     <= i_num_cnt;
          acc_words <= '0;
          addr_r    <= '0;
          o_idle    <= 1'b0;
          if (i_num_cnt == '0) begin
            state  <= S_DONE;
            o_done <= 1'b1;
          end else begin
            state   <= S_RUN;
            o_write <= 1'b1;
          end
        end
        // Leave RUN once the last word's write cycle is on the port.
        S_RUN: if (ce_b && (acc_words == num_r)) begin
          state   <= S_DONE;
          o_write <= 1'b0;
          o_done  <= 1'b1;
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_idle <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          o_idle  <= 1'b1;
          o_write <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRAM_STREAM_WRITER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           o_checksum <= '0;
    else if (start)      o_checksum <= '0;
    else if (word_valid) o_checksum <= o_checksum + word;
  end
`endif

endmodule

// File: doc/bram_stream_writer.md
Name: bram_stream_writer

Overview:
- Write-side counterpart of the FC core's BRAM reader.
- Accepts a valid/ready stream of IN_DATA_WIDTH-bit elements and packs NUM_CORE elements per DWIDTH word, first element in the MSBs, giving {a_0,a_1,a_2,a_3}.
- Writes i_num_cnt words to consecutive addresses of one true_dpbram port, starting at address 0.
- Used to fill the node, weight and bias BRAMs through hardware rather than by backdoor.

Parameters:
- CNT_BIT, 31, width of the word-count input.
- DWIDTH, 32, BRAM data width; must equal NUM_CORE*IN_DATA_WIDTH.
- AWIDTH, 12, BRAM address width.
- MEM_SIZE, 4096, BRAM depth in words.
- IN_DATA_WIDTH, 8, stream element width.
- NUM_CORE, 4, elements per word.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_run  in  1  start pulse; sampled only in IDLE.
- i_num_cnt  in  CNT_BIT  number of words to write; latched on start.
- o_idle  out  1  high in IDLE.
- o_write  out  1  high in RUN.
- o_done  out  1  one-cycle pulse in DONE.
- s_valid  in  1  stream element valid.
- s_data  in  IN_DATA_WIDTH  stream element.
- s_ready  out  1  element accepted when s_valid && s_ready.
- addr_b  out  AWIDTH  BRAM port address.
- ce_b  out  1  BRAM chip enable.
- we_b  out  1  BRAM write enable.
- d_b  out  DWIDTH  BRAM write data.

Behaviour:
- Reset values: state=IDLE, o_idle=1, o_write=0, o_done=0, s_ready=0, ce_b=0, we_b=0, addr_b=0, d_b=0; all counters and the pack register cleared.
- Reset asserted mid-operation: transfer aborted, partial word discarded, no further BRAM writes.
- FSM IDLE -> RUN on i_run=1. i_num_cnt is latched as num_r, the word counter and element index are cleared, and the write address is set to 0.
- IDLE -> DONE directly if i_run=1 and i_num_cnt=0; no BRAM access occurs.
- RUN -> DONE in the cycle after the final word's BRAM write is issued.
- DONE -> IDLE unconditionally after one cycle.
- i_run is ignored outside IDLE.
- s_ready = 1 only in RUN while accepted words < num_r. It drops combinationally in the cycle after the last element of word num_r-1 is accepted.
- Packing: element k of a word (k=0..NUM_CORE-1) goes to bits [DWIDTH-1-k*IN_DATA_WIDTH -: IN_DATA_WIDTH]. The element index wraps to 0 after NUM_CORE-1.
- Write latency: in the cycle after element NUM_CORE-1 is accepted, the block drives ce_b=1, we_b=1, d_b=packed word and addr_b=current address for exactly one cycle. The address then increments.
- Address wrap: after writing MEM_SIZE-1 the next address is 0; the word count is unaffected.
- Back-to-back operation: a new word may be packed while the previous one is being written, so there is no throughput bubble. Full rate is 1 element/clk.
- Between writes: ce_b=0, we_b=0; addr_b and d_b hold their last values.
- Input bubbles (s_valid=0) stall packing with no side effects. Elements offered outside RUN are not accepted.

Optional Feature:
- Macro BRAM_STREAM_WRITER_CHECKSUM_EN.
- Defined: adds output o_checksum [DWIDTH-1:0], the modulo-2^DWIDTH sum of every word written since the last start. It is cleared on reset and on IDLE->RUN/DONE, and is stable from the o_done pulse until the next start.
- Undefined: the port and its logic are absent.

Decomposition:
- Shared package fc_core_pkg holds:
  - the FSM state encoding (S_IDLE, S_RUN, S_DONE; 2 bits);
  - default width constants (CNT_BIT, DWIDTH, AWIDTH, MEM_SIZE, IN_DATA_WIDTH, NUM_CORE);
  - the element-to-bit-slice mapping function, shared with the reader.
- One natural sub-module: elem_packer. It takes element valid/data and outputs word_valid and the packed word, and owns the element index.
- The top level keeps the FSM, word/address counters and BRAM drive.

Test Plan:
- Basic fill: i_num_cnt=3, elements 1..12 streamed back-to-back -> writes 0x01020304@0, 0x05060708@1, 0x090A0B0C@2; o_done pulses once; BRAM matches via port B readback.
- Throttled input: s_valid toggling 1/0 with i_num_cnt=2 -> same packed contents as the unthrottled run; no extra writes; s_ready=0 after the 8th element.
- Zero count: i_num_cnt=0 -> o_done one cycle after start; ce_b never asserted; o_idle returns next cycle.
- Wrap: MEM_SIZE=16 and i_num_cnt=18 -> words 16 and 17 land at addresses 0 and 1, overwriting them; o_done pulses after 18 writes.
- Reset mid-run: assert reset after 6 of 8 elements with i_num_cnt=2 -> only address 0 written, state IDLE; a subsequent start performs a full transfer correctly.
- Checksum (macro defined): words 0x01020304 and 0x05060708 -> o_checksum=0x06080A0C at o_done.
